// File: rtl/gauss3x3_stream.sv
// Purpose: streaming 3x3 Gaussian (1-2-1 / 2-4-2 / 1-2-1) over raster-order 8-bit pixels.
// Latency: 2 cycles from accepted pixel to wrreq; 1 pixel/cycle sustained.
// Backpressure: in_ready = ~wrfull; results already in flight (<= 2) are always written.
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   pix_in/pix_valid  input pixel stream; accepted when pix_valid & in_ready
//   in_ready          combinational ~wrfull
//   wrfull            output FIFO almost-full (fewer than 3 free entries)
//   wrdata/wrreq      15-bit result and write strobe into the output FIFO
//   frame_done        one-cycle pulse the cycle after the last pixel of a frame is accepted
module gauss3x3_stream #(
  parameter int WIDTH  = 300,
  parameter int HEIGHT = 300
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        in_ready,
  input  logic        wrfull,
  output logic [14:0] wrdata,
  output logic        wrreq,
  output logic        frame_done
);

  localparam logic [8:0] COL_LAST = 9'(WIDTH - 1);
  localparam logic [8:0] ROW_LAST = 9'(HEIGHT - 1);

  logic       accept;
  logic       last_pix;
  logic [8:0] col;
  logic [8:0] row;

  // lb1 holds the previous line, lb2 the line before that.
  logic [7:0] lb1 [WIDTH];
  logic [7:0] lb2 [WIDTH];

  // Window: t* = row-2, m* = row-1, b* = current row; index 2 is the newest column.
  logic [7:0] t0, t1, t2;
  logic [7:0] m0, m1, m2;
  logic [7:0] b0, b1, b2;

  // Stage-1 flags travel alongside the registered window.
  logic        s1_vld;
  logic        s1_zero;
  logic [11:0] sum;

  assign in_ready = ~wrfull;
  assign accept   = pix_valid & in_ready;
  assign last_pix = (col == COL_LAST) && (row == ROW_LAST);

  // Max 16*255 = 4080, so 12 bits hold the sum exactly.
  assign sum = {4'b0, t0} + {3'b0, t1, 1'b0} + {4'b0, t2}
             + {3'b0, m0, 1'b0} + {2'b0, m1, 2'b0} + {3'b0, m2, 1'b0}
             + {4'b0, b0} + {3'b0, b1, 1'b0} + {4'b0, b2};

  // Line buffers carry no reset; rows 0-1 of every frame refill them before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb1[col] <= pix_in;
      lb2[col] <= lb1[col];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      t0         <= '0;
      t1         <= '0;
      t2         <= '0;
      m0         <= '0;
      m1         <= '0;
      m2         <= '0;
      b0         <= '0;
      b1         <= '0;
      b2         <= '0;
      s1_vld     <= 1'b0;
      s1_zero    <= 1'b0;
      wrreq      <= 1'b0;
      wrdata     <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= accept && last_pix;

      // Stage 1: every accept from row 2 on yields exactly one write; the first
      // two columns of a line have no full window and emit zero.
      s1_vld  <= accept && (row >= 9'd2);
      s1_zero <= (col < 9'd2);

      // Stage 2: register the result with its strobe.
      wrreq  <= s1_vld;
      wrdata <= (s1_vld && !s1_zero) ? {3'b000, sum} : 15'd0;

      if (accept) begin
        t0 <= t1;
        t1 <= t2;
        t2 <= lb2[col];
        m0 <= m1;
        m1 <= m2;
        m2 <= lb1[col];
        b0 <= b1;
        b1 <= b2;
        b2 <= pix_in;

        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? 9'd0 : row + 9'd1;
        end else begin
          col <= col + 9'd1;
        end
      end
    end
  end

endmodule

// File: doc/gauss3x3_stream.md
# gauss3x3_stream

Streaming 3x3 Gaussian convolution stage for the 300-pixel-wide filter datapath. It accepts 8-bit pixels in raster order, keeps two line buffers, and computes the 1-2-1 / 2-4-2 / 1-2-1 weighted sum. It writes one 15-bit result per accepted pixel into the output FIFO, starting at the third row. The downstream line-output stage reads that FIFO 300 words per line.

## Interface
- WIDTH, 300: pixels per line; column counter is 9 bits.
- HEIGHT, 300: lines per frame; row counter is 9 bits.
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- pix_in  in  8  input pixel.
- pix_valid  in  1  pix_in valid this cycle.
- in_ready  out  1  stage can accept a pixel; accept = pix_valid & in_ready.
- wrfull  in  1  FIFO almost-full; asserted while fewer than 3 free entries remain.
- wrdata  out  15  filtered result to FIFO.
- wrreq  out  1  FIFO write strobe, one word per cycle.
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- in_ready = ~wrfull, combinational. There is no other stall source.
- Counters col (0..WIDTH-1) and row (0..HEIGHT-1) advance only on accept.
  - col wraps to 0 at WIDTH-1 and row increments.
  - At row HEIGHT-1 / col WIDTH-1, both wrap to 0 and frame_done pulses on the next cycle.
- Line buffers: two WIDTH x 8 memories, addressed by col.
  - On accept: lb1[col] <= pix_in and lb2[col] <= old lb1[col].
  - lb1 holds row-1 and lb2 holds row-2.
- The 3x3 window is three shift columns of {lb2, lb1, pix_in}, shifted on accept only.
  - Top row t0..t2, middle m0..m2, bottom b0..b2; index 2 is newest.
- Sum S = t0 + 2t1 + t2 + 2m0 + 4m1 + 2m2 + b0 + 2b1 + b2.
  - Unsigned, maximum 4080, 12 bits.
  - wrdata = {3'b000, S}. No normalisation and no saturation; the full range is exact.
- Output emission: every accept with row >= 2 produces exactly one write, so each output line is WIDTH words.
  - col >= 2: wrdata = S, centred on pixel (row-1, col-1).
  - col < 2 (window not yet filled on this line): wrdata = 0.
  - Accepts in rows 0 and 1 produce no write; they only fill the line buffers.
- Frame boundary: line buffers are not cleared between frames. Rows 0-1 of the next frame overwrite them before any output depends on them.
- Reset (at any time, including mid-line or mid-frame):
  - col, row, window registers and pipeline valids go to 0.
  - wrreq=0, wrdata=0, frame_done=0.
  - In-flight results are discarded.
  - Line buffer contents are don't-care.

## Timing
- Two-stage pipeline.
  - Cycle N: accept; window and buffer update registered.
  - Cycle N+1: S registered with its emit flag.
  - Cycle N+2: wrreq=1 with wrdata valid.
- Latency is fixed at 2 cycles from accept to wrreq. Throughput is 1 pixel/cycle when wrfull=0.
- wrfull affects only new accepts. Results already in flight (at most 2) are always written, which the 3-entry almost-full margin guarantees.
- A simultaneous accept and wrfull rise: the accept counts (in_ready is sampled in the same cycle as wrfull).
- pix_valid while in_ready=0: the pixel is not taken and no state changes. The source must hold it.
- frame_done is asserted at N+1 after the final accept, independent of wrreq.
- Reset values: in_ready follows ~wrfull; wrreq=0, wrdata=0, frame_done=0.

## Test plan
- Constant image 100, WIDTH=300, HEIGHT=4, no backpressure:
  - no wrreq during rows 0-1;
  - rows 2-3 each give 300 writes: 2 zeros then 298 x 1600;
  - 600 writes total; frame_done pulses once.
- Impulse: 255 at (1,1), all else 0:
  - the row-2 write at col 2 = 1020;
  - col 3 = 510;
  - row-3 writes at cols 2 and 3 = 510 and 255;
  - all other writes = 0.
- Maximum: all pixels 255 -> every col >= 2 result = 4080 (0x0FF0); bits 14:12 are always 0.
- Backpressure: wrfull high for 5 cycles mid-row 2.
  - in_ready low for those cycles; at most 2 trailing writes;
  - the output sequence is identical to the no-stall run, with no loss or duplication.
- Random pix_valid gaps: result stream equals the golden model; each wrreq occurs exactly 2 cycles after its accept.
- Reset mid-row 2, then a full new frame:
  - wrreq=0 the cycle after rst;
  - the new frame yields exactly (HEIGHT-2)*WIDTH correct writes.
